// File: rtl/cpu_pkg.sv
// Shared constants and types for the GPIO binary-to-BCD display engine.
// Optional macro CPU_FULL_WIDTH_EN widens the converted input to 27 bits and adds saturation.
// All widths below derive from IN_W and ITER; DIGITS*4 must stay 32.
package cpu_pkg;
`ifdef CPU_FULL_WIDTH_EN
    localparam int IN_W = 27;
`else
    localparam int IN_W = 18;
`endif
    localparam int DIGITS = 8;
    localparam int ITER   = 3;
    localparam int STEPS  = (IN_W + ITER - 1) / ITER;
    localparam int BCD_W  = DIGITS * 4;
    localparam int CNT_W  = $clog2(ITER);
    localparam logic [31:0] BCD_MAX = 32'h99999999;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;
endpackage

// File: rtl/cpu_bcd_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift left taking bit_in.
// Latency: purely combinational.
// Backpressure: none; chained STEPS times per clock by the cpu sequencer.
module bcd_step
    import cpu_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             bit_in,
    output logic [BCD_W-1:0] bcd_out
);
    logic [BCD_W-1:0] adj;
    logic             unused_msb;

    // Per-digit add-3 correction ahead of the shift
    always_comb begin
        adj = bcd_in;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_in[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = bcd_in[d*4 +: 4] + 4'd3;
            end
        end
    end

    // The corrected MSB shifts out; it is always 0 for in-range values
    assign bcd_out    = {adj[BCD_W-2:0], bit_in};
    assign unused_msb = adj[BCD_W-1];
endmodule

// File: rtl/cpu.sv
// GPIO display engine: converts gpio_in[IN_W-1:0] to 8-digit packed BCD on gpio_out.
// Latency: ITER clocks after the capturing edge (at most 5 clocks from an input change).
// Backpressure: none; any input change restarts conversion, gpio_out updates only on completion.
// Optional macro: CPU_FULL_WIDTH_EN (27-bit input, saturation to 99999999).
module cpu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
);
    logic [IN_W-1:0]  src;
    logic [IN_W-1:0]  sh;
    logic [BCD_W-1:0] bcd;
    logic [CNT_W-1:0] cnt;
    state_t           state;
`ifdef CPU_FULL_WIDTH_EN
    logic             sat;
`endif

    logic [STEPS:0][BCD_W-1:0] bcd_chain;
    logic [STEPS:0][IN_W-1:0]  sh_chain;
    logic [STEPS-1:0][BCD_W-1:0] stepped;
    logic [STEPS-1:0]          en;
    logic [BCD_W-1:0]          result;
    logic                      unused_hi;

    assign bcd_chain[0] = bcd;
    assign sh_chain[0]  = sh;

    // STEPS chained steps per clock; steps beyond IN_W total pass through untouched
    for (genvar k = 0; k < STEPS; k++) begin : g_step
        bcd_step u_step (
            .bcd_in  (bcd_chain[k]),
            .bit_in  (sh_chain[k][IN_W-1]),
            .bcd_out (stepped[k])
        );
        assign en[k]          = (int'(cnt) * STEPS + k) < IN_W;
        assign bcd_chain[k+1] = en[k] ? stepped[k] : bcd_chain[k];
        assign sh_chain[k+1]  = en[k] ? {sh_chain[k][IN_W-2:0], 1'b0} : sh_chain[k];
    end

`ifdef CPU_FULL_WIDTH_EN
    assign result = sat ? BCD_MAX : bcd_chain[STEPS];
`else
    assign result = bcd_chain[STEPS];
`endif

    // Switch bits above IN_W are intentionally ignored
    assign unused_hi = ^gpio_in[31:IN_W];

    // Change detect restarts the sequencer; the final cycle publishes the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out <= '0;
            src      <= '0;
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            state    <= IDLE;
`ifdef CPU_FULL_WIDTH_EN
            sat      <= 1'b0;
`endif
        end else if (gpio_in[IN_W-1:0] != src) begin
            src   <= gpio_in[IN_W-1:0];
            sh    <= gpio_in[IN_W-1:0];
            bcd   <= '0;
            cnt   <= '0;
            state <= CONV;
`ifdef CPU_FULL_WIDTH_EN
            sat   <= gpio_in[IN_W-1:0] > IN_W'(99999999);
`endif
        end else if (state == CONV) begin
            bcd <= bcd_chain[STEPS];
            sh  <= sh_chain[STEPS];
            if (cnt == CNT_W'(ITER - 1)) begin
                gpio_out <= result;
                state    <= IDLE;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: scoreboard of expected display updates vs a decimal reference model.
module tb_cpu;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio_in = 32'd0;
    logic [31:0] gpio_out;

    cpu dut (
        .clk      (clk),
        .rst      (rst),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_disp = 32'd0;
    logic [31:0] model_src  = 32'd0;
    logic [31:0] last_out   = 32'd0;

    function automatic logic [31:0] low_bits(logic [31:0] v);
        longint n;
        n = longint'(v) & ((64'd1 << IN_W) - 1);
        return 32'(n);
    endfunction

    // Decimal digits by repeated division, saturating above 8 digits
    function automatic logic [31:0] ref_bcd(logic [31:0] v);
        logic [31:0] r;
        longint      n;
        r = 32'd0;
        n = longint'(low_bits(v));
        if (n > 99999999) return 32'h99999999;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drive a value for 'hold' edges; only conversions that run to completion are expected
    task automatic apply(input logic [31:0] v, input int hold);
        logic [31:0] lo;
        logic [31:0] e;
        @(posedge clk);
        #1;
        gpio_in = v;
        lo = low_bits(v);
        if (lo != model_src) begin
            model_src = lo;
            e = ref_bcd(v);
            if (hold >= 4 && e != model_disp) begin
                sbq.push_back('{val: e, cyc: cyc});
                model_disp = e;
            end
        end
        repeat (hold - 1) @(posedge clk);
    endtask

    // Monitor: every visible change of gpio_out must match the next expected value
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_out = gpio_out;
        end else if (gpio_out !== last_out) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_update: got %h expected no change from %h", gpio_out, last_out);
            end else begin
                e = sbq.pop_front();
                check("conversion", gpio_out, e.val);
                tests++;
                if (cyc - e.cyc > 5) begin
                    fails++;
                    $display("FAIL latency: got %0d clocks expected <= 5", cyc - e.cyc);
                end
            end
            last_out = gpio_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        int          hold;
        int          wait_cnt;

        #12 check("reset_state_a", gpio_out, 32'h0);
        #10 check("reset_state_b", gpio_out, 32'h0);
        #5 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_idle", gpio_out, 32'h0);

        apply(32'h00003039, 7);
        apply(32'h00026789, 7);
        apply(32'h0003FFFF, 7);
        apply(32'h00000009, 7);
        apply(32'hFFFC0010, 7);
        apply(32'h00000010, 7);
        #1 check("upper_bits_ignored", gpio_out, model_disp);
        apply(32'd100000, 1);
        apply(32'd999, 7);

        // Reset one clock into a conversion
        @(posedge clk);
        #1 gpio_in = 32'd54321;
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check("reset_async", gpio_out, 32'h0);
        sbq.delete();
        model_disp = 32'd0;
        model_src  = 32'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_src = low_bits(gpio_in);
        sbq.push_back('{val: ref_bcd(gpio_in), cyc: cyc});
        model_disp = ref_bcd(gpio_in);
        repeat (6) @(posedge clk);
        #1 check("post_reset_convert", gpio_out, 32'h00054321);

        // Random values, short holds abort and long holds must complete
        for (int i = 0; i < 40; i++) begin
            do begin
                v = $urandom;
                if ($urandom_range(0, 3) == 0) v = (v & 32'hFFFF0000) | $urandom_range(0, 99);
            end while (low_bits(v) == model_src);
            hold = $urandom_range(1, 8);
            apply(v, hold);
        end
        apply(gpio_in ^ 32'h1, 7);

        wait_cnt = 0;
        while (sbq.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        @(negedge clk);
        check("final_display", gpio_out, model_disp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
